johnson_decoder: RTL

Receive-side companion to the 4-bit Johnson (twisted-ring) counter. The block samples a 4-bit Johnson code, converts it to a 3-bit binary phase index and checks that each sampled code is the legal successor of the previous one. It flags illegal codes and sequence breaks and keeps a saturating error count. It sits after any Johnson-coded phase/state bus as its decoder and integrity monitor.

---
 rtl/johnson_decoder.sv | 94 +++++++++
 1 files changed

// File: rtl/johnson_decoder.sv
// Decoder and integrity monitor for a 4-bit Johnson-coded phase bus: maps each
// sampled code to a 3-bit phase, flags illegal words and sequence breaks, counts errors.
module johnson_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       code,
  output logic             out_valid,
  output logic [2:0]       phase,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_nx;
  logic [2:0]       last, last_nx;
  logic [2:0]       dec;
  logic             legal;
  logic             ov_nx, il_nx, se_nx, bump;
  logic [2:0]       ph_nx;
  logic [ERR_W-1:0] cnt_nx;

  always_comb begin
    legal = 1'b1;
    dec   = 3'd0;
    case (code)
      4'b0000: dec = 3'd0;
      4'b1000: dec = 3'd1;
      4'b1100: dec = 3'd2;
      4'b1110: dec = 3'd3;
      4'b1111: dec = 3'd4;
      4'b0111: dec = 3'd5;
      4'b0011: dec = 3'd6;
      4'b0001: dec = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    ov_nx    = 1'b0;
    il_nx    = 1'b0;
    se_nx    = 1'b0;
    ph_nx    = phase;
    bump     = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        il_nx    = 1'b1;
        bump     = 1'b1;
        state_nx = UNLOCKED;
      end else begin
        ov_nx    = 1'b1;
        ph_nx    = dec;
        last_nx  = dec;
        state_nx = LOCKED;
        // Successor check only once there is history; a mismatch resyncs to dec.
        if (state == LOCKED && dec != 3'(last + 3'd1)) begin
          se_nx = 1'b1;
          bump  = 1'b1;
        end
      end
    end
    cnt_nx = (bump && err_cnt != {ERR_W{1'b1}}) ? err_cnt + 1'b1 : err_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= UNLOCKED;
      last      <= 3'd0;
      out_valid <= 1'b0;
      phase     <= 3'd0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      out_valid <= ov_nx;
      phase     <= ph_nx;
      illegal   <= il_nx;
      seq_err   <= se_nx;
      err_cnt   <= cnt_nx;
    end
  end

  assign locked = (state == LOCKED);

endmodule
